// File: rtl/rf_pkg.sv
// Shared types and constants for the rename-tag scheduler: tag width, ring depth and ROB entry layout.
package rf_pkg;

    localparam int TAG_W    = 3;
    localparam int NUM_TAGS = 7;
    localparam int XLEN     = 32;
    localparam int REG_W    = 5;

    typedef logic [TAG_W-1:0] rf_tag_t;

    localparam rf_tag_t TAG_NONE  = 3'd0;
    localparam rf_tag_t TAG_FIRST = 3'd1;
    localparam rf_tag_t TAG_LAST  = 3'd7;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } rob_entry_t;

    // Tag 0 means "no dependency", so pointers step 1..7 and wrap back to 1.
    function automatic rf_tag_t tag_inc(input rf_tag_t t);
        if (t == TAG_LAST) begin
            return TAG_FIRST;
        end else begin
            return t + 3'd1;
        end
    endfunction

endpackage

// File: rtl/rf_tag_ring.sv
// Head/tail/occupancy bookkeeping for the 7-entry tag ring; pointers live in 1..7.
module rf_tag_ring
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    push,
    input  logic    pop,
    output rf_tag_t head,
    output rf_tag_t tail,
    output rf_tag_t count,
    output logic    full,
    output logic    empty
);

    rf_tag_t head_q, head_d;
    rf_tag_t tail_q, tail_d;
    rf_tag_t count_q, count_d;

    // Pointer and occupancy next state; flush returns the ring to its reset shape.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = TAG_FIRST;
            tail_d  = TAG_FIRST;
            count_d = TAG_NONE;
        end else begin
            head_d = pop  ? tag_inc(head_q) : head_q;
            tail_d = push ? tag_inc(tail_q) : tail_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Ring state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= TAG_FIRST;
            tail_q  <= TAG_FIRST;
            count_q <= TAG_NONE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;
    assign full  = (count_q == rf_tag_t'(NUM_TAGS));
    assign empty = (count_q == TAG_NONE);

endmodule

// File: rtl/rf_tag_scheduler.sv
// In-order rename-tag allocator and commit sequencer in front of the register file.
// Optional RF_TAG_FULL_BYPASS_EN lets a full ring accept an issue in the cycle its head retires.
module rf_tag_scheduler
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    output logic             issue_ready,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             done_valid,
    input  logic [TAG_W-1:0] done_tag,
    input  logic [XLEN-1:0]  done_data,
    output logic             rf_instruction,
    output logic [REG_W-1:0] rf_rd,
    output logic [TAG_W-1:0] rf_dependency_num,
    output logic             rf_commit,
    output logic [REG_W-1:0] rf_reg_num,
    output logic [XLEN-1:0]  rf_data,
    output logic [TAG_W-1:0] rf_num_in,
    output logic [TAG_W-1:0] busy_count
);

    rob_entry_t ent_q [NUM_TAGS+1];
    rob_entry_t ent_d [NUM_TAGS+1];

    rf_tag_t head_s, tail_s, count_s;
    logic    full_s, empty_s;
    logic    issue_fire_s, commit_fire_s, done_hit_s;

    logic             rf_instruction_q, rf_instruction_d;
    logic [REG_W-1:0] rf_rd_q, rf_rd_d;
    rf_tag_t          rf_dependency_num_q, rf_dependency_num_d;
    logic             rf_commit_q, rf_commit_d;
    logic [REG_W-1:0] rf_reg_num_q, rf_reg_num_d;
    logic [XLEN-1:0]  rf_data_q, rf_data_d;
    rf_tag_t          rf_num_in_q, rf_num_in_d;

    rf_tag_ring u_ring (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (issue_fire_s),
        .pop   (commit_fire_s),
        .head  (head_s),
        .tail  (tail_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Results are recorded only; commit looks at registered state, so a done never bypasses to commit.
    assign commit_fire_s = !empty_s && ent_q[head_s].valid && ent_q[head_s].done && !flush;
    assign done_hit_s    = done_valid && (done_tag != TAG_NONE) && ent_q[done_tag].valid
                           && !ent_q[done_tag].done && !flush;
`ifdef RF_TAG_FULL_BYPASS_EN
    assign issue_ready   = (!full_s || commit_fire_s) && !flush;
`else
    assign issue_ready   = !full_s && !flush;
`endif
    assign issue_fire_s  = issue_valid && issue_ready;
    assign issue_tag     = tail_s;

    // Entry updates: retire first, then result capture, then allocation (a bypassed issue may reuse the head slot).
    always_comb begin
        ent_d = ent_q;
        if (flush) begin
            for (int i = 0; i <= NUM_TAGS; i++) begin
                ent_d[i] = '0;
            end
        end else begin
            if (commit_fire_s) begin
                ent_d[head_s] = '0;
            end else begin
                ent_d[head_s] = ent_q[head_s];
            end
            if (done_hit_s) begin
                ent_d[done_tag].done = 1'b1;
                ent_d[done_tag].data = done_data;
            end else begin
                ent_d[done_tag] = ent_d[done_tag];
            end
            if (issue_fire_s) begin
                ent_d[tail_s] = '{valid: 1'b1, done: 1'b0, rd: issue_rd, data: 32'd0};
            end else begin
                ent_d[tail_s] = ent_d[tail_s];
            end
        end
    end

    // Registered RF-side strobes and payloads; payloads hold between strobes.
    always_comb begin
        rf_instruction_d    = issue_fire_s;
        rf_rd_d             = issue_fire_s  ? issue_rd           : rf_rd_q;
        rf_dependency_num_d = issue_fire_s  ? tail_s             : rf_dependency_num_q;
        rf_commit_d         = commit_fire_s;
        rf_reg_num_d        = commit_fire_s ? ent_q[head_s].rd   : rf_reg_num_q;
        rf_data_d           = commit_fire_s ? ent_q[head_s].data : rf_data_q;
        rf_num_in_d         = commit_fire_s ? head_s             : rf_num_in_q;
    end

    // Entry array and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i <= NUM_TAGS; i++) begin
                ent_q[i] <= '0;
            end
            rf_instruction_q    <= 1'b0;
            rf_rd_q             <= 5'd0;
            rf_dependency_num_q <= TAG_NONE;
            rf_commit_q         <= 1'b0;
            rf_reg_num_q        <= 5'd0;
            rf_data_q           <= 32'd0;
            rf_num_in_q         <= TAG_NONE;
        end else begin
            ent_q               <= ent_d;
            rf_instruction_q    <= rf_instruction_d;
            rf_rd_q             <= rf_rd_d;
            rf_dependency_num_q <= rf_dependency_num_d;
            rf_commit_q         <= rf_commit_d;
            rf_reg_num_q        <= rf_reg_num_d;
            rf_data_q           <= rf_data_d;
            rf_num_in_q         <= rf_num_in_d;
        end
    end

    assign rf_instruction    = rf_instruction_q;
    assign rf_rd             = rf_rd_q;
    assign rf_dependency_num = rf_dependency_num_q;
    assign rf_commit         = rf_commit_q;
    assign rf_reg_num        = rf_reg_num_q;
    assign rf_data           = rf_data_q;
    assign rf_num_in         = rf_num_in_q;
    assign busy_count        = count_s;

endmodule

// File: tb/tb_rf_tag_scheduler.sv
// Self-checking bench for rf_tag_scheduler: directed scenarios plus randomized traffic against a queue model.
module tb_rf_tag_scheduler;
    import rf_pkg::*;

`ifdef RF_TAG_FULL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, issue_valid, done_valid;
    logic [REG_W-1:0] issue_rd;
    logic [TAG_W-1:0] done_tag;
    logic [XLEN-1:0]  done_data;
    logic             issue_ready, rf_instruction, rf_commit;
    logic [TAG_W-1:0] issue_tag, rf_dependency_num, rf_num_in, busy_count;
    logic [REG_W-1:0] rf_rd, rf_reg_num;
    logic [XLEN-1:0]  rf_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              tag;
        int              rd;
        bit              done;
        logic [XLEN-1:0] data;
    } m_ent_t;

    rf_tag_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .done_valid(done_valid), .done_tag(done_tag), .done_data(done_data),
        .rf_instruction(rf_instruction), .rf_rd(rf_rd), .rf_dependency_num(rf_dependency_num),
        .rf_commit(rf_commit), .rf_reg_num(rf_reg_num), .rf_data(rf_data), .rf_num_in(rf_num_in),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        done_valid  = 1'b0;
        flush       = 1'b0;
        issue_rd    = '0;
        done_tag    = '0;
        done_data   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue_valid = 1'b1;
            issue_rd    = 5'(i + 1);
            tick();
        end
        idle();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rf_instruction !== 1'b0) begin errors++; $display("FAIL reset_instr: got %0d exp 0", rf_instruction); end
        checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %0d exp 0", rf_commit); end
        checks++; if (rf_rd !== 5'd0 || rf_dependency_num !== 3'd0) begin errors++; $display("FAIL reset_issue_out: got rd %0d dep %0d exp 0 0", rf_rd, rf_dependency_num); end
        checks++; if (rf_reg_num !== 5'd0 || rf_data !== 32'd0 || rf_num_in !== 3'd0) begin errors++; $display("FAIL reset_commit_out: got %0d %0h %0d exp 0 0 0", rf_reg_num, rf_data, rf_num_in); end
        checks++; if (busy_count !== 3'd0) begin errors++; $display("FAIL reset_busy: got %0d exp 0", busy_count); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d exp 1", issue_ready); end
        checks++; if (issue_tag !== 3'd1) begin errors++; $display("FAIL reset_tag: got %0d exp 1", issue_tag); end
    endtask

    task automatic test_issue();
        do_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        #1;
        checks++; if (issue_tag !== 3'd1) begin errors++; $display("FAIL issue_tag: got %0d exp 1", issue_tag); end
        tick();
        idle();
        checks++; if (rf_instruction !== 1'b1 || rf_rd !== 5'd5 || rf_dependency_num !== 3'd1) begin errors++; $display("FAIL issue_out: got %0d/%0d/%0d exp 1/5/1", rf_instruction, rf_rd, rf_dependency_num); end
        checks++; if (busy_count !== 3'd1) begin errors++; $display("FAIL issue_busy: got %0d exp 1", busy_count); end
        tick();
        checks++; if (rf_instruction !== 1'b0) begin errors++; $display("FAIL issue_pulse: got %0d exp 0", rf_instruction); end
    endtask

    task automatic test_in_order();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3; tick();
        issue_rd = 5'd4; tick();
        idle();
        done_valid = 1'b1; done_tag = 3'd2; done_data = 32'hAA; tick();
        checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL order_early: got %0d exp 0", rf_commit); end
        done_tag = 3'd1; done_data = 32'h55; tick();
        idle();
        checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL order_nobypass: got %0d exp 0", rf_commit); end
        tick();
        checks++; if (rf_commit !== 1'b1 || rf_reg_num !== 5'd3 || rf_data !== 32'h55 || rf_num_in !== 3'd1) begin errors++; $display("FAIL order_first: got %0d/%0d/%0h/%0d exp 1/3/55/1", rf_commit, rf_reg_num, rf_data, rf_num_in); end
        tick();
        checks++; if (rf_commit !== 1'b1 || rf_reg_num !== 5'd4 || rf_data !== 32'hAA || rf_num_in !== 3'd2) begin errors++; $display("FAIL order_second: got %0d/%0d/%0h/%0d exp 1/4/aa/2", rf_commit, rf_reg_num, rf_data, rf_num_in); end
        tick();
        checks++; if (rf_commit !== 1'b0 || busy_count !== 3'd0) begin errors++; $display("FAIL order_drain: got %0d/%0d exp 0/0", rf_commit, busy_count); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        issue_n(7);
        checks++; if (issue_ready !== 1'b0 || busy_count !== 3'd7) begin errors++; $display("FAIL full_state: got ready %0d busy %0d exp 0 7", issue_ready, busy_count); end
        done_valid = 1'b1; done_tag = 3'd1; done_data = 32'h11; tick();
        idle();
        #1;
        checks++; if (issue_ready !== BYPASS) begin errors++; $display("FAIL full_commit_ready: got %0d exp %0d", issue_ready, BYPASS); end
        tick();
        checks++; if (rf_commit !== 1'b1 || rf_num_in !== 3'd1 || rf_data !== 32'h11 || busy_count !== 3'd6) begin errors++; $display("FAIL full_commit: got %0d/%0d/%0h/%0d exp 1/1/11/6", rf_commit, rf_num_in, rf_data, busy_count); end
        checks++; if (issue_ready !== 1'b1 || issue_tag !== 3'd1) begin errors++; $display("FAIL wrap_tag: got ready %0d tag %0d exp 1 1", issue_ready, issue_tag); end
        issue_valid = 1'b1; issue_rd = 5'd9; tick();
        idle();
        checks++; if (rf_instruction !== 1'b1 || rf_dependency_num !== 3'd1 || rf_rd !== 5'd9 || busy_count !== 3'd7) begin errors++; $display("FAIL wrap_issue: got %0d/%0d/%0d/%0d exp 1/1/9/7", rf_instruction, rf_dependency_num, rf_rd, busy_count); end
    endtask

    task automatic test_full_bypass();
        int  n    = 0;
        bit  seen = 1'b0;
        do_reset();
        issue_n(7);
        done_valid = 1'b1; done_tag = 3'd1; done_data = 32'h22; tick();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd10;
        while (n < 6 && !seen) begin
            tick();
            n++;
            if (rf_instruction === 1'b1) seen = 1'b1;
        end
        idle();
        checks++; if (!seen || n != (BYPASS ? 1 : 2)) begin errors++; $display("FAIL bypass_latency: got seen %0d cycles %0d exp 1 %0d", seen, n, BYPASS ? 1 : 2); end
        checks++; if (rf_dependency_num !== 3'd1 || busy_count !== 3'd7) begin errors++; $display("FAIL bypass_tag: got dep %0d busy %0d exp 1 7", rf_dependency_num, busy_count); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_n(3);
        flush = 1'b1; done_valid = 1'b1; done_tag = 3'd1; done_data = 32'h77; tick();
        idle();
        #1;
        checks++; if (rf_commit !== 1'b0 || rf_instruction !== 1'b0) begin errors++; $display("FAIL flush_strobes: got %0d/%0d exp 0/0", rf_commit, rf_instruction); end
        checks++; if (busy_count !== 3'd0 || issue_tag !== 3'd1 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got busy %0d tag %0d ready %0d exp 0 1 1", busy_count, issue_tag, issue_ready); end
        tick();
        checks++; if (rf_commit !== 1'b0) begin errors++; $display("FAIL flush_done_dropped: got %0d exp 0", rf_commit); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_n(5);
        done_valid = 1'b1; done_tag = 3'd1; done_data = 32'hBEEF; tick();
        idle();
        tick();
        checks++; if (rf_commit !== 1'b1 || busy_count !== 3'd4) begin errors++; $display("FAIL midrst_setup: got commit %0d busy %0d exp 1 4", rf_commit, busy_count); end
        rst = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7; tick();
        rst = 1'b1;
        idle();
        #1;
        checks++; if (rf_instruction !== 1'b0 || rf_rd !== 5'd0 || rf_dependency_num !== 3'd0) begin errors++; $display("FAIL midrst_issue_out: got %0d/%0d/%0d exp 0/0/0", rf_instruction, rf_rd, rf_dependency_num); end
        checks++; if (rf_commit !== 1'b0 || rf_reg_num !== 5'd0 || rf_data !== 32'd0 || rf_num_in !== 3'd0) begin errors++; $display("FAIL midrst_commit_out: got %0d/%0d/%0h/%0d exp 0/0/0/0", rf_commit, rf_reg_num, rf_data, rf_num_in); end
        checks++; if (busy_count !== 3'd0 || issue_tag !== 3'd1) begin errors++; $display("FAIL midrst_state: got busy %0d tag %0d exp 0 1", busy_count, issue_tag); end
        done_valid = 1'b1; done_tag = 3'd3; done_data = 32'h33; tick();
        idle();
        tick();
        checks++; if (rf_commit !== 1'b0 || busy_count !== 3'd0) begin errors++; $display("FAIL midrst_done_ignored: got commit %0d busy %0d exp 0 0", rf_commit, busy_count); end
    endtask

    task automatic test_random();
        m_ent_t          mq[$];
        m_ent_t          e;
        int              nt = 1;
        bit              commit_now, ready, fire;
        int              exp_reg, exp_tag, rd_now;
        logic [XLEN-1:0] exp_data;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            flush       = ($urandom_range(0, 99) < 3);
            issue_valid = ($urandom_range(0, 99) < 55);
            issue_rd    = 5'($urandom);
            done_valid  = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0 && $urandom_range(0, 99) < 80)
                done_tag = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                done_tag = 3'($urandom_range(0, 7));
            done_data = $urandom;
            #1;
            commit_now = !flush && mq.size() > 0 && mq[0].done;
            ready      = !flush && (mq.size() < NUM_TAGS || (BYPASS && commit_now));
            fire       = issue_valid && ready;
            rd_now     = int'(issue_rd);
            checks++; if (issue_ready !== ready || int'(issue_tag) != nt) begin errors++; $display("FAIL rnd_ready cyc %0d: got ready %0d tag %0d exp %0d %0d", cyc, issue_ready, issue_tag, ready, nt); end
            exp_reg = 0; exp_tag = 0; exp_data = '0;
            if (commit_now) begin
                exp_reg = mq[0].rd; exp_tag = mq[0].tag; exp_data = mq[0].data;
            end
            exp_tag = commit_now ? exp_tag : 0;
            if (flush) begin
                mq.delete();
                nt = 1;
            end else begin
                if (commit_now) void'(mq.pop_front());
                if (done_valid && done_tag != 3'd0) begin
                    for (int k = 0; k < mq.size(); k++) begin
                        if (mq[k].tag == int'(done_tag) && !mq[k].done) begin
                            e = mq[k]; e.done = 1'b1; e.data = done_data; mq[k] = e;
                        end
                    end
                end
                if (fire) begin
                    e = '{tag: nt, rd: rd_now, done: 1'b0, data: '0};
                    mq.push_back(e);
                    nt = (nt == NUM_TAGS) ? 1 : nt + 1;
                end
            end
            tick();
            checks++; if (rf_instruction !== fire || rf_commit !== commit_now || int'(busy_count) != mq.size()) begin errors++; $display("FAIL rnd_strobes cyc %0d: got %0d/%0d/%0d exp %0d/%0d/%0d", cyc, rf_instruction, rf_commit, busy_count, fire, commit_now, mq.size()); end
            if (fire) begin
                checks++; if (int'(rf_rd) != rd_now || int'(rf_dependency_num) != (nt == 1 ? NUM_TAGS : nt - 1)) begin errors++; $display("FAIL rnd_issue cyc %0d: got rd %0d dep %0d", cyc, rf_rd, rf_dependency_num); end
            end
            if (commit_now) begin
                checks++; if (int'(rf_reg_num) != exp_reg || rf_data !== exp_data || int'(rf_num_in) != exp_tag) begin errors++; $display("FAIL rnd_commit cyc %0d: got %0d/%0h/%0d exp %0d/%0h/%0d", cyc, rf_reg_num, rf_data, rf_num_in, exp_reg, exp_data, exp_tag); end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_issue();
        test_in_order();
        test_full_wrap();
        test_full_bypass();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_tag_scheduler.md
Name: rf_tag_scheduler

Overview:
- In-order tag allocator and commit sequencer for the register file's dependency-tag interface.
- Hands out 3-bit rename tags (1..7; 0 = "no dependency") to decoded instructions and drives the RF's instruction/rd/dependency_num issue inputs.
- Collects execution results per tag and retires them to the RF commit port strictly in allocation order.
- Functions as a minimal 7-entry reorder ring sitting between decode, execute units and the RF.

Parameters:
- TAG_W, 3, tag width; tag 0 is reserved as "ready/no dependency".
- NUM_TAGS, 7, usable tags (2**TAG_W - 1); ring depth.
- XLEN, 32, data width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all in-flight entries.
- issue_valid  in  1  decoder presents an instruction.
- issue_rd  in  REG_W  destination register.
- issue_ready  out  1  a tag is available.
- issue_tag  out  TAG_W  tag to be assigned on accept (combinational, = tail).
- done_valid  in  1  execution result valid.
- done_tag  in  TAG_W  tag of the result.
- done_data  in  XLEN  result value.
- rf_instruction  out  1  RF issue strobe.
- rf_rd  out  REG_W  rd to RF.
- rf_dependency_num  out  TAG_W  allocated tag to RF.
- rf_commit  out  1  RF commit strobe.
- rf_reg_num  out  REG_W  committed rd.
- rf_data  out  XLEN  committed value.
- rf_num_in  out  TAG_W  committed tag.
- busy_count  out  TAG_W  entries in flight (0..7).

Behaviour:
- Reset (rst==0 at posedge):
  - head=tail=1, count=0, all entries invalid/not-done.
  - All outputs 0 except issue_ready=1 and issue_tag=1.
- Ring pointers range 1..7; increment wraps 7->1. Tag 0 is never allocated.
- Issue fire = issue_valid && issue_ready && !flush; issue_ready = (count<NUM_TAGS) && !flush.
  - On fire: entry[tail] <= {valid=1, done=0, rd=issue_rd}; tail advances.
  - Next cycle: rf_instruction=1, rf_rd=issue_rd, rf_dependency_num=old tail (latency 1, one-cycle pulse).
- Done:
  - When done_valid, and done_tag is nonzero and entry valid and not done: set done, store done_data.
  - Tag 0, an unallocated tag, or an already-done tag is ignored with no state change.
- Commit fire = count>0 && entry[head].valid && entry[head].done && !flush.
  - Next cycle: rf_commit=1, rf_reg_num=entry.rd, rf_data=entry.data, rf_num_in=head.
  - Entry invalidated, head advances.
  - At most one commit per cycle.
- Done and commit in the same cycle for the head entry: done is recorded, and commit occurs the following cycle (no bypass).
- Issue and commit in the same cycle: count unchanged; both strobes fire next cycle.
- rd==0 entries are allocated and committed normally; the RF discards writes to x0.
- Full (count==7): issue_ready=0, decoder must hold. Empty: no commit.
- Flush (priority over issue, done and commit):
  - Clears all entries; head=tail=1, count=0.
  - Next-cycle rf_instruction and rf_commit are 0.
- Mid-operation reset behaves identically to flush and additionally zeroes the registered outputs.

Optional Feature:
- RF_TAG_FULL_BYPASS_EN.
  - Defined: issue_ready = (count<NUM_TAGS || commit_fire) && !flush. A full ring accepts an issue in the same cycle the head retires; the freed head tag becomes the new tail tag.
  - Undefined: issue_ready requires count<NUM_TAGS. A full ring stalls issue for one extra cycle after a commit.

Decomposition:
- Shared package rf_pkg:
  - Constants TAG_W, NUM_TAGS, XLEN, REG_W, and TAG_NONE=0.
  - Typedef rf_tag_t.
  - Struct rob_entry_t {valid, done, rd, data}.
- One sub-module: rf_tag_ring. Owns head, tail and count; provides wrap-increment (7->1), full/empty, and the next-tag outputs.

Test Plan:
- Reset, then issue rd=5 -> issue_tag=1; next cycle rf_instruction=1, rf_rd=5, rf_dependency_num=1; busy_count=1.
- Issue rd=3 (tag 1) and rd=4 (tag 2); done tag 2 data=0xAA, then tag 1 data=0x55 -> commits appear in order: (reg 3, 0x55, tag 1), then (reg 4, 0xAA, tag 2).
- Issue 7 instructions with no done -> issue_ready=0 and busy_count=7. Done tag 1 -> commit tag 1. Next issue receives tag 1, confirming the 7->1 wrap.
- Full ring plus head done, issue_valid held -> accept in the commit cycle with RF_TAG_FULL_BYPASS_EN defined, one cycle later without it.
- Three entries in flight, flush asserted together with done_valid for the head -> no rf_commit; busy_count=0; next issue_tag=1.
- Reset pulled low mid-stream with 4 in flight -> all outputs 0; issue_tag=1; done_valid for tag 3 afterwards is ignored.
